load_store_buffer: RTL and testbench

- Circular FIFO between the reservation station and the memory controller; sits directly downstream of the reservation station's LS issue port.
- Accepts load/store ops whose operands are ready and computes the effective address on entry.
- Executes entries strictly in arrival order, one memory access outstanding. Loads execute speculatively; stores execute only after ROB commit.
- Load results go on the CDB. Store address/data readiness is reported to the ROB.

---
 rtl/load_store_buffer.sv | 165 ++++++++++++++++
 tb/tb_load_store_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_buffer.sv
// In-order load/store buffer between the LS issue port and the memory controller.
// Loads issue speculatively; stores wait for ROB commit; one access in flight.
module load_store_buffer #(
  parameter int LSBSIZE = 8,
  parameter int PTRW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ls_mission,
  input  logic [3:0]  ls_ins_rnm,
  input  logic [5:0]  ls_op_type,
  input  logic [31:0] ls_addr_offset,
  input  logic [31:0] ls_ins_rs1,
  input  logic [31:0] store_ins_rs2,
  output logic        lsb_full,
  input  logic        store_commit_flag,
  input  logic [3:0]  store_commit_rename,
  input  logic        rs_flush,
  output logic        store_ready_flag,
  output logic [3:0]  store_ready_rename,
  output logic        lsb_result_flag,
  output logic [3:0]  lsb_result_rename,
  output logic [31:0] lsb_result_value,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata
);

  localparam logic [5:0] OP_LB = 6'd11, OP_LH = 6'd12, OP_LW = 6'd13, OP_LBU = 6'd14,
                         OP_LHU = 6'd15, OP_SB = 6'd16, OP_SH = 6'd17, OP_SW = 6'd18;
  localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(LSBSIZE);
  localparam logic [PTRW:0] FULL_THR = (PTRW+1)'(LSBSIZE - 2);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;

  logic [LSBSIZE-1:0] e_valid, e_store, e_commit;
  logic [3:0]         e_rnm  [LSBSIZE];
  logic [5:0]         e_op   [LSBSIZE];
  logic [31:0]        e_addr [LSBSIZE];
  logic [31:0]        e_data [LSBSIZE];
  logic [PTRW-1:0]    head, tail;
  logic [PTRW:0]      count;
  logic               abort;
  logic               in_store, push, pop, issue;

  function automatic logic [1:0] size_of(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: size_of = 2'd0;
      OP_LH, OP_LHU, OP_SH: size_of = 2'd1;
      default:              size_of = 2'd2;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] d);
    case (op)
      OP_LB:   extend = {{24{d[7]}}, d[7:0]};
      OP_LBU:  extend = {24'd0, d[7:0]};
      OP_LH:   extend = {{16{d[15]}}, d[15:0]};
      OP_LHU:  extend = {16'd0, d[15:0]};
      OP_LW:   extend = d;
      default: extend = d;
    endcase
  endfunction

  assign lsb_full = (count >= FULL_THR);

  always_comb begin
    in_store = (ls_op_type == OP_SB) || (ls_op_type == OP_SH) || (ls_op_type == OP_SW);
    push     = ls_mission && !rs_flush && (count != FULL_CNT);
    pop      = ((state == IDLE) && !e_valid[head] && (count != '0)) ||
               ((state == WAIT) && mem_done);
    // Issue is held off during a flush cycle so a doomed load never reaches memory.
    issue    = (state == IDLE) && !rs_flush && e_valid[head] &&
               (!e_store[head] || e_commit[head]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      abort              <= 1'b0;
      e_valid            <= '0;
      e_store            <= '0;
      e_commit           <= '0;
      store_ready_flag   <= 1'b0;
      store_ready_rename <= '0;
      lsb_result_flag    <= 1'b0;
      lsb_result_rename  <= '0;
      lsb_result_value   <= '0;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= '0;
      mem_size           <= '0;
    end else if (rdy) begin
      store_ready_flag <= 1'b0;
      lsb_result_flag  <= 1'b0;

      if (rs_flush) begin
        for (int unsigned i = 0; i < LSBSIZE; i++)
          if (!(e_store[i] && e_commit[i])) e_valid[i] <= 1'b0;
      end else if (store_commit_flag) begin
        for (int unsigned i = 0; i < LSBSIZE; i++)
          if (e_valid[i] && e_store[i] && (e_rnm[i] == store_commit_rename))
            e_commit[i] <= 1'b1;
      end

      case (state)
        IDLE: if (issue) begin
          mem_req   <= 1'b1;
          mem_we    <= e_store[head];
          mem_addr  <= e_addr[head];
          mem_wdata <= e_data[head];
          mem_size  <= size_of(e_op[head]);
          state     <= WAIT;
        end
        WAIT: if (mem_done) begin
          if (!e_store[head] && !abort && !rs_flush) begin
            lsb_result_flag   <= 1'b1;
            lsb_result_rename <= e_rnm[head];
            lsb_result_value  <= extend(e_op[head], mem_rdata);
          end
          mem_req <= 1'b0;
          abort   <= 1'b0;
          state   <= IDLE;
        end else if (rs_flush && !e_store[head]) begin
          abort <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        e_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end

      if (push) begin
        e_valid[tail]  <= 1'b1;
        e_store[tail]  <= in_store;
        e_commit[tail] <= 1'b0;
        e_rnm[tail]    <= ls_ins_rnm;
        e_op[tail]     <= ls_op_type;
        e_addr[tail]   <= ls_ins_rs1 + ls_addr_offset;
        e_data[tail]   <= store_ins_rs2;
        tail           <= tail + 1'b1;
        if (in_store) begin
          store_ready_flag   <= 1'b1;
          store_ready_rename <= ls_ins_rnm;
        end
      end

      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed, table-driven bench for load_store_buffer with hand-computed expectations.
module tb_load_store_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        ls_mission;
  logic [3:0]  ls_ins_rnm;
  logic [5:0]  ls_op_type;
  logic [31:0] ls_addr_offset, ls_ins_rs1, store_ins_rs2;
  logic        lsb_full;
  logic        store_commit_flag;
  logic [3:0]  store_commit_rename;
  logic        rs_flush;
  logic        store_ready_flag;
  logic [3:0]  store_ready_rename;
  logic        lsb_result_flag;
  logic [3:0]  lsb_result_rename;
  logic [31:0] lsb_result_value;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_done;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_buffer #(.LSBSIZE(8), .PTRW(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ls_mission(ls_mission), .ls_ins_rnm(ls_ins_rnm), .ls_op_type(ls_op_type),
    .ls_addr_offset(ls_addr_offset), .ls_ins_rs1(ls_ins_rs1), .store_ins_rs2(store_ins_rs2),
    .lsb_full(lsb_full), .store_commit_flag(store_commit_flag),
    .store_commit_rename(store_commit_rename), .rs_flush(rs_flush),
    .store_ready_flag(store_ready_flag), .store_ready_rename(store_ready_rename),
    .lsb_result_flag(lsb_result_flag), .lsb_result_rename(lsb_result_rename),
    .lsb_result_value(lsb_result_value), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14,
                         LHU = 6'd15, SB = 6'd16, SW = 6'd18;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  rnm;
    logic [31:0] rs1;
    logic [31:0] off;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [1:0]  exp_size;
    logic [31:0] exp_value;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic enq(input logic [5:0] op, input logic [3:0] rnm, input logic [31:0] rs1,
                     input logic [31:0] off, input logic [31:0] rs2);
    ls_mission = 1'b1; ls_op_type = op; ls_ins_rnm = rnm;
    ls_ins_rs1 = rs1; ls_addr_offset = off; store_ins_rs2 = rs2;
    tick();
    ls_mission = 1'b0;
  endtask

  task automatic commit(input logic [3:0] rnm);
    store_commit_flag = 1'b1; store_commit_rename = rnm;
    tick();
    store_commit_flag = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int unsigned n = 0;
    while (!mem_req && n < 30) begin
      tick();
      n++;
    end
    chk(name, 32'(mem_req), 32'h1);
  endtask

  task automatic done_pulse(input logic [31:0] rdata);
    mem_done = 1'b1; mem_rdata = rdata;
    tick();
    mem_done = 1'b0;
  endtask

  task automatic load_txn(input string name, input logic [3:0] rnm, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] rdata,
                          input logic [31:0] value);
    wait_req({name, "_req"});
    chk({name, "_addr"}, mem_addr, addr);
    chk({name, "_size"}, 32'(mem_size), 32'(size));
    chk({name, "_we"}, 32'(mem_we), 32'h0);
    done_pulse(rdata);
    chk({name, "_flag"}, 32'(lsb_result_flag), 32'h1);
    chk({name, "_rnm"}, 32'(lsb_result_rename), 32'(rnm));
    chk({name, "_value"}, lsb_result_value, value);
    chk({name, "_req_drop"}, 32'(mem_req), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int seen_req, seen_res;
    rst = 1'b1; rdy = 1'b1; ls_mission = 1'b0; ls_ins_rnm = '0; ls_op_type = '0;
    ls_addr_offset = '0; ls_ins_rs1 = '0; store_ins_rs2 = '0;
    store_commit_flag = 1'b0; store_commit_rename = '0; rs_flush = 1'b0;
    mem_done = 1'b0; mem_rdata = '0;

    vecs[0] = '{LW,  4'd3, 32'h100,      32'hFFFFFFFC, 32'hDEADBEEF, 32'hFC,  2'd2, 32'hDEADBEEF};
    vecs[1] = '{LB,  4'd1, 32'h20,       32'h0,        32'h00000080, 32'h20,  2'd0, 32'hFFFFFF80};
    vecs[2] = '{LBU, 4'd2, 32'h20,       32'h0,        32'h00000080, 32'h20,  2'd0, 32'h00000080};
    vecs[3] = '{LH,  4'd4, 32'h1C,       32'h4,        32'h00008001, 32'h20,  2'd1, 32'hFFFF8001};
    vecs[4] = '{LHU, 4'd5, 32'h30,       32'h2,        32'h12348001, 32'h32,  2'd1, 32'h00008001};
    vecs[5] = '{LW,  4'd6, 32'hFFFFFFF0, 32'h20,       32'h7FFFFFFF, 32'h10,  2'd2, 32'h7FFFFFFF};
    vecs[6] = '{LB,  4'd7, 32'h0,        32'h44,       32'hFFFFFF7F, 32'h44,  2'd0, 32'h0000007F};

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_full", 32'(lsb_full), 32'h0);
    chk("rst_store_ready", 32'(store_ready_flag), 32'h0);
    chk("rst_result", 32'(lsb_result_flag), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_count", 32'(dut.count), 32'h0);

    // Load table: address generation, size and extension
    for (int i = 0; i < 7; i++) begin
      enq(vecs[i].op, vecs[i].rnm, vecs[i].rs1, vecs[i].off, 32'h0);
      load_txn($sformatf("ld%0d", i), vecs[i].rnm, vecs[i].exp_addr, vecs[i].exp_size,
               vecs[i].rdata, vecs[i].exp_value);
    end
    tick();
    chk("result_pulse_one_cycle", 32'(lsb_result_flag), 32'h0);

    // Store waits for commit and blocks a younger load
    enq(SW, 4'd5, 32'h40, 32'h8, 32'h12345678);
    chk("st_ready_flag", 32'(store_ready_flag), 32'h1);
    chk("st_ready_rnm", 32'(store_ready_rename), 32'h5);
    enq(LW, 4'd7, 32'h80, 32'h0, 32'h0);
    chk("st_ready_pulse", 32'(store_ready_flag), 32'h0);
    tick(); tick(); tick();
    chk("st_uncommitted_no_req", 32'(mem_req), 32'h0);
    commit(4'd5);
    wait_req("st_req");
    chk("st_we", 32'(mem_we), 32'h1);
    chk("st_addr", mem_addr, 32'h48);
    chk("st_wdata", mem_wdata, 32'h12345678);
    chk("st_size", 32'(mem_size), 32'h2);
    tick(); tick(); tick();
    chk("st_held_req", 32'(mem_req), 32'h1);
    chk("st_held_we", 32'(mem_we), 32'h1);
    done_pulse(32'h0);
    chk("st_req_drop", 32'(mem_req), 32'h0);
    chk("st_no_cdb", 32'(lsb_result_flag), 32'h0);
    load_txn("ld_after_st", 4'd7, 32'h80, 2'd2, 32'hCAFEF00D, 32'hCAFEF00D);

    // Full threshold and pointer wrap
    do_reset();
    for (int i = 0; i < 6; i++) begin
      enq(LW, 4'(i), 32'h1000, 32'(4 * i), 32'h0);
      chk($sformatf("full_after_%0d", i + 1), 32'(lsb_full), (i >= 5) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 6; i++) begin
      load_txn($sformatf("drain%0d", i), 4'(i), 32'h1000 + 32'(4 * i), 2'd2,
               32'(i) * 32'h11, 32'(i) * 32'h11);
      if (i == 0) chk("full_drop_at_5", 32'(lsb_full), 32'h0);
    end
    for (int i = 6; i < 10; i++) enq(LW, 4'(i), 32'h2000, 32'(4 * i), 32'h0);
    for (int i = 6; i < 10; i++)
      load_txn($sformatf("wrap%0d", i), 4'(i), 32'h2000 + 32'(4 * i), 2'd2,
               32'hA0 + 32'(i), 32'hA0 + 32'(i));
    chk("wrap_tail", 32'(dut.tail), 32'h2);
    chk("wrap_count", 32'(dut.count), 32'h0);

    // Flush with a committed store in flight
    do_reset();
    enq(SB, 4'd2, 32'h200, 32'h1, 32'h000000AB);
    chk("fl_ready_rnm", 32'(store_ready_rename), 32'h2);
    commit(4'd2);
    wait_req("fl_sb_req");
    chk("fl_sb_addr", mem_addr, 32'h201);
    chk("fl_sb_size", 32'(mem_size), 32'h0);
    chk("fl_sb_wdata", mem_wdata, 32'hAB);
    enq(SW, 4'd4, 32'h300, 32'h0, 32'h1);
    enq(LW, 4'd6, 32'h400, 32'h0, 32'h0);
    rs_flush = 1'b1; tick(); rs_flush = 1'b0;
    tick(); tick();
    chk("fl_sb_still_req", 32'(mem_req), 32'h1);
    done_pulse(32'h0);
    chk("fl_sb_done", 32'(mem_req), 32'h0);
    seen_req = 0; seen_res = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req) seen_req++;
      if (lsb_result_flag) seen_res++;
      tick();
    end
    chk("fl_no_issue", 32'(seen_req), 32'h0);
    chk("fl_no_cdb", 32'(seen_res), 32'h0);
    chk("fl_count", 32'(dut.count), 32'h0);

    // Flush while a load waits: data discarded, FSM recovers
    do_reset();
    enq(LW, 4'd9, 32'h300, 32'h0, 32'h0);
    wait_req("ab_req");
    rs_flush = 1'b1; tick(); rs_flush = 1'b0;
    tick(); tick();
    chk("ab_still_req", 32'(mem_req), 32'h1);
    done_pulse(32'h55);
    chk("ab_no_cdb", 32'(lsb_result_flag), 32'h0);
    chk("ab_req_drop", 32'(mem_req), 32'h0);
    tick();
    chk("ab_no_cdb_later", 32'(lsb_result_flag), 32'h0);
    chk("ab_count", 32'(dut.count), 32'h0);
    enq(LH, 4'd10, 32'h500, 32'h2, 32'h0);
    load_txn("ab_next", 4'd10, 32'h502, 2'd1, 32'h00007FFF, 32'h00007FFF);

    // rdy hold and reset during WAIT
    do_reset();
    enq(LW, 4'd11, 32'h400, 32'h0, 32'h0);
    wait_req("rs_req");
    rdy = 1'b0;
    mem_done = 1'b1; tick(); mem_done = 1'b0;
    tick(); tick();
    chk("rdy_hold_req", 32'(mem_req), 32'h1);
    chk("rdy_hold_cdb", 32'(lsb_result_flag), 32'h0);
    rdy = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_wait_req", 32'(mem_req), 32'h0);
    chk("rst_wait_count", 32'(dut.count), 32'h0);
    tick(); tick();
    chk("rst_wait_idle", 32'(mem_req), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
